mips_mc_control: RTL
====================

Name: mips_mc_control

Overview:
- Multicycle MIPS control FSM, directly upstream of the ALU.
- Drives the 3-bit ALU op, ALU operand selects, memory request and all datapath write enables from the IR opcode/funct fields and the ALU zero flag.
- Adds a memory ready handshake with timeout, and a sticky trap state for illegal instructions and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 15: maximum wait cycles in a memory state before trapping.
- CNT_W, 4: width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  IR[31:26]; stable from DECODE onward.
- funct  input  6  IR[5:0].
- zero  input  1  ALU result==0 flag.
- mem_ready  input  1  memory completion strobe.
- mem_req  output  1  memory access request.
- mem_we  output  1  write qualifier for mem_req.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  output  1  load IR.
- pc_write  output  1  load PC.
- pc_src  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- alu_src_a  output  1  ALU A select: 0=PC, 1=reg A.
- alu_src_b  output  2  ALU B select: 00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2.
- alu_op  output  3  ALU op: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 XOR, 7 reserved.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  destination select: 0=rt, 1=rd.
- mem_to_reg  output  1  writeback source: 0=ALUOut, 1=MDR.
- trap  output  1  sticky error flag.
- trap_cause  output  2  trap reason: 01=illegal instruction, 10=memory timeout.
- state  output  4  current state, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, TRAP=15.
- Reset:
  - rst_n low forces state=FETCH, wait counter=0, trap=0, trap_cause=0.
  - While rst_n is low, every output is 0 (gated combinationally).
  - Reset asserted mid-operation aborts the instruction immediately; no partial writes occur after assertion.
- Outputs are Moore, decoded from state; exceptions are pc_write in FETCH/BRANCH and ir_write. Unlisted outputs are 0.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Go to DECODE on mem_ready.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut).
  - Next state by opcode: 0x00→EXEC, 0x23/0x2B→MEMADR, 0x04→BRANCH, 0x02→JUMP.
  - Opcode 0x00 with funct not in {0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT} → TRAP, cause 01.
  - Any other opcode → TRAP, cause 01.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=ADD; go to MEMRD (0x23) or MEMWR (0x2B).
- MEMRD: mem_req=1, iord=1; go to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1; go to FETCH on mem_ready.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op mapped from funct as listed above; then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, pc_write=zero; then FETCH unconditionally.
- JUMP: pc_src=10, pc_write=1; then FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES with mem_ready=0 → TRAP, cause 10.
  - mem_ready arriving on the same cycle as the limit wins: normal transition.
- TRAP:
  - trap=1, trap_cause held, all enables 0, mem_req=0.
  - Exits only on reset.
- Cycles per instruction with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.

Optional Feature:
- Macro IMM_ALU_EN.
- Defined:
  - DECODE routes 0x08 ADDI, 0x0C ANDI, 0x0D ORI, 0x0A SLTI to IEXEC.
  - IEXEC: alu_src_a=1, alu_src_b=10, alu_op ADD/AND/OR/SLT respectively; then IWB.
  - IWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
- Undefined: those opcodes trap with cause 01; states 10 and 11 are unreachable.

Test Plan:
- R-type: reset, opcode=0x00 funct=0x22, mem_ready=1 → states 0,1,6,7,0; alu_op=3 in EXEC; reg_write=1, reg_dst=1 only in ALUWB.
- lw with wait states: opcode=0x23, mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles, iord=1; MEMWB asserts reg_write and mem_to_reg.
- beq: opcode=0x04 with zero=1 → pc_write=1, pc_src=01 in BRANCH; repeat with zero=0 → pc_write=0; both return to FETCH.
- Illegal instruction: opcode=0x3F, or opcode=0 with funct=0x01 → TRAP after DECODE, trap=1, cause=01; held 20 cycles with no write enables.
- Timeout: mem_ready=0 in FETCH → TRAP after exactly 15 wait cycles, cause=10; a second run with mem_ready on cycle 15 → DECODE, no trap.
- Reset mid-operation: assert rst_n=0 during MEMWR → outputs 0 immediately; release → FETCH, trap=0. Under IMM_ALU_EN, opcode=0x0D → IEXEC with alu_op=1, then IWB.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: Moore-decoded datapath controls, memory handshake with timeout, sticky trap.
// Optional immediate ALU instructions (ADDI/ANDI/ORI/SLTI) are enabled by defining IMM_ALU_EN.
module mips_mc_control #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cause;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_op(input logic [5:0] f);
    case (f)
      6'h20:   return 3'd2;
      6'h22:   return 3'd3;
      6'h24:   return 3'd0;
      6'h25:   return 3'd1;
      6'h26:   return 3'd6;
      6'h27:   return 3'd5;
      6'h2A:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

`ifdef IMM_ALU_EN
  function automatic logic imm_legal(input logic [5:0] op);
    return (op == 6'h08) || (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0A);
  endfunction

  function automatic logic [2:0] imm_op(input logic [5:0] op);
    case (op)
      6'h0C:   return 3'd0;
      6'h0D:   return 3'd1;
      6'h0A:   return 3'd4;
      default: return 3'd2;
    endcase
  endfunction
`endif

  // The wait counter only advances in memory states while stalled; every transition clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_cause <= 2'b00;
    end else begin
      r_cnt <= '0;
      case (r_state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            if (r_state == S_FETCH)      r_state <= S_DECODE;
            else if (r_state == S_MEMRD) r_state <= S_MEMWB;
            else                         r_state <= S_FETCH;
          end else if (r_cnt == LP_LIMIT) begin
            r_state <= S_TRAP;
            r_cause <= 2'b10;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            6'h00: begin
              if (funct_legal(funct)) r_state <= S_EXEC;
              else begin
                r_state <= S_TRAP;
                r_cause <= 2'b01;
              end
            end
            6'h23, 6'h2B: r_state <= S_MEMADR;
            6'h04:        r_state <= S_BRANCH;
            6'h02:        r_state <= S_JUMP;
            default: begin
`ifdef IMM_ALU_EN
              if (imm_legal(opcode)) r_state <= S_IEXEC;
              else begin
                r_state <= S_TRAP;
                r_cause <= 2'b01;
              end
`else
              r_state <= S_TRAP;
              r_cause <= 2'b01;
`endif
            end
          endcase
        end
        S_MEMADR: begin
          if (opcode == 6'h23) r_state <= S_MEMRD;
          else                 r_state <= S_MEMWR;
        end
        S_EXEC:  r_state <= S_ALUWB;
        S_IEXEC: r_state <= S_IWB;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced low combinationally while reset is held.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'd0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    trap_cause = 2'b00;
    state      = 4'd0;
    if (rst_n) begin
      state      = r_state;
      trap_cause = r_cause;
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = 3'd2;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = 3'd2;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 3'd2;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = funct_op(funct);
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 3'd3;
          pc_src    = 2'b01;
          pc_write  = zero;
        end
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
`ifdef IMM_ALU_EN
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = imm_op(opcode);
        end
        S_IWB: reg_write = 1'b1;
`endif
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
